// File: rtl/reaction_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl_if
// Description : Handshake/display bundle between the reaction-timer control
//               stage and its neighbours (tick divider, buttons, LFSR,
//               display driver).
// Revision    : 1.0 - initial release
// ============================================================================
interface reaction_timer_ctrl_if #(
    parameter int CNT_W = 14
);
    logic             tick;
    logic             start;
    logic             stop;
    logic [11:0]      delay;
    logic             delay_req;
    logic             led;
    logic [CNT_W-1:0] reaction_time;
    logic             done;
    logic             early;
    logic             timeout;

    // Environment side: drives tick/buttons/delay, observes results
    modport master (
        output tick, start, stop, delay,
        input  delay_req, led, reaction_time, done, early, timeout
    );

    // Controller side
    modport slave (
        input  tick, start, stop, delay,
        output delay_req, led, reaction_time, done, early, timeout
    );
endinterface
`default_nettype wire

// File: rtl/reaction_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : reaction_timer_ctrl
// Description : Reaction-timer trial sequencer. Requests a random delay from
//               the LFSR, waits that many ms ticks with the LED dark, lights
//               the LED and measures the reaction time in ms until Stop.
//               Flags early presses and saturating timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_timer_ctrl #(
    parameter int CNT_W     = 14,
    parameter int MAX_MS    = 9999,
    parameter int MIN_DELAY = 500
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    reaction_timer_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARM     = 3'd1,
        S_LOAD    = 3'd2,
        S_WAIT    = 3'd3,
        S_MEASURE = 3'd4,
        S_DONE    = 3'd5,
        S_EARLY   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX    = CNT_W'(MAX_MS);
    localparam logic [CNT_W-1:0] C_MAX_M1 = CNT_W'(MAX_MS - 1);
    localparam logic [CNT_W-1:0] C_MIN    = CNT_W'(MIN_DELAY);
    localparam logic [CNT_W-1:0] C_ONE    = CNT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] dcnt, dcnt_nx;
    logic [CNT_W-1:0] mcnt, mcnt_nx;
    logic [CNT_W-1:0] time_q, time_nx;
    logic             delay_req_q, delay_req_nx;
    logic             led_q, led_nx;
    logic             done_q, done_nx;
    logic             early_q, early_nx;
    logic             timeout_q, timeout_nx;

    // State, counters and registered outputs; reset aborts any trial at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            dcnt        <= '0;
            mcnt        <= '0;
            time_q      <= '0;
            delay_req_q <= 1'b0;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
            early_q     <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            dcnt        <= dcnt_nx;
            mcnt        <= mcnt_nx;
            time_q      <= time_nx;
            delay_req_q <= delay_req_nx;
            led_q       <= led_nx;
            done_q      <= done_nx;
            early_q     <= early_nx;
            timeout_q   <= timeout_nx;
        end
    end

    // Next-state and next-output decode; everything holds unless changed
    always_comb begin
        state_nx     = state;
        dcnt_nx      = dcnt;
        mcnt_nx      = mcnt;
        time_nx      = time_q;
        delay_req_nx = 1'b0;
        led_nx       = led_q;
        done_nx      = done_q;
        early_nx     = early_q;
        timeout_nx   = timeout_q;

        case (state)
            S_IDLE, S_DONE, S_EARLY: begin
                // Start takes priority over a simultaneous Stop here
                if (bus.start) begin
                    state_nx     = S_ARM;
                    delay_req_nx = 1'b1;
                    led_nx       = 1'b0;
                    done_nx      = 1'b0;
                    early_nx     = 1'b0;
                    timeout_nx   = 1'b0;
                    time_nx      = '0;
                end
            end
            S_ARM: begin
                // LFSR latches its word on this edge; capture it next cycle
                state_nx = S_LOAD;
            end
            S_LOAD: begin
                dcnt_nx  = (bus.delay == 12'd0) ? C_MIN : CNT_W'(bus.delay);
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (bus.stop) begin
                    state_nx = S_EARLY;
                    early_nx = 1'b1;
                end else if (bus.tick) begin
                    // Last tick of the delay lights the LED; dcnt stays >= 1
                    if (dcnt <= C_ONE) begin
                        state_nx = S_MEASURE;
                        led_nx   = 1'b1;
                        mcnt_nx  = '0;
                    end else begin
                        dcnt_nx = dcnt - C_ONE;
                    end
                end
            end
            S_MEASURE: begin
                if (bus.stop) begin
                    // Report the count before any same-cycle tick
                    state_nx = S_DONE;
                    time_nx  = mcnt;
                    done_nx  = 1'b1;
                    led_nx   = 1'b0;
                end else if (bus.tick) begin
                    if (mcnt >= C_MAX_M1) begin
                        state_nx   = S_DONE;
                        mcnt_nx    = C_MAX;
                        time_nx    = C_MAX;
                        done_nx    = 1'b1;
                        timeout_nx = 1'b1;
                        led_nx     = 1'b0;
                    end else begin
                        mcnt_nx = mcnt + C_ONE;
                    end
                end
            end
            default: begin
                state_nx   = S_IDLE;
                led_nx     = 1'b0;
                done_nx    = 1'b0;
                early_nx   = 1'b0;
                timeout_nx = 1'b0;
                time_nx    = '0;
            end
        endcase
    end

    assign bus.delay_req     = delay_req_q;
    assign bus.led           = led_q;
    assign bus.reaction_time = time_q;
    assign bus.done          = done_q;
    assign bus.early         = early_q;
    assign bus.timeout       = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_reaction_timer_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_reaction_timer_ctrl
// Description : Self-checking bench for reaction_timer_ctrl. A trial is
//               modelled as (effective delay E, stop tick index S): Stop
//               before E ticks is early, otherwise time = S - E, capped at
//               MAX_MS as a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_timer_ctrl;

    localparam int CNT_W     = 14;
    localparam int MAX_MS    = 9999;
    localparam int MIN_DELAY = 500;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    reaction_timer_ctrl_if #(.CNT_W(CNT_W)) bus();

    reaction_timer_ctrl #(
        .CNT_W    (CNT_W),
        .MAX_MS   (MAX_MS),
        .MIN_DELAY(MIN_DELAY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic drive_idle();
        bus.tick  = 1'b0;
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    // One full trial: start, delay capture, wait, measure, result, then
    // a few cycles of stray Stop/Tick that must not disturb the result.
    task automatic run_trial(input logic [11:0] d, input int s_tick, input int tick_pct,
                             input bit collide, input bit start_with_stop,
                             input bit inject_start, input string name);
        int e, tcount, cyc, limit, exp_time;
        bit ended, exp_early, exp_timeout;
        e           = (d == 12'd0) ? MIN_DELAY : int'(d);
        tcount      = 0;
        cyc         = 0;
        ended       = 1'b0;
        exp_early   = 1'b0;
        exp_timeout = 1'b0;
        exp_time    = 0;
        limit       = ((e + MAX_MS + 10) * 100) / tick_pct + 50;

        @(negedge clk);
        bus.start = 1'b1;
        bus.stop  = start_with_stop;
        bus.tick  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
        bus.delay = d;
        tests++;
        if (bus.delay_req !== 1'b1 || bus.done !== 1'b0 || bus.early !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.reaction_time !== '0 || bus.led !== 1'b0) begin
            fails++;
            $display("FAIL %s arm: req=%b done=%b early=%b timeout=%b time=%0d led=%b, expected req=1 others 0",
                     name, bus.delay_req, bus.done, bus.early, bus.timeout, bus.reaction_time, bus.led);
        end
        @(negedge clk);
        tests++;
        if (bus.delay_req !== 1'b0) begin
            fails++;
            $display("FAIL %s load: req=%b, expected 0", name, bus.delay_req);
        end

        while (!ended && cyc < limit) begin
            @(negedge clk);
            cyc++;
            tests++;
            if (bus.led !== (tcount >= e) || bus.done !== 1'b0 || bus.early !== 1'b0) begin
                fails++;
                $display("FAIL %s run ticks=%0d: led=%b done=%b early=%b, expected led=%b done=0 early=0",
                         name, tcount, bus.led, bus.done, bus.early, (tcount >= e));
            end
            bus.stop  = (tcount == s_tick);
            bus.tick  = (collide && bus.stop) ? 1'b1 : ($urandom_range(99) < tick_pct);
            bus.start = inject_start && (cyc % 7 == 3);
            if (bus.stop) begin
                ended = 1'b1;
                if (tcount < e) exp_early = 1'b1;
                else            exp_time  = tcount - e;
            end else if (bus.tick) begin
                tcount++;
                if (tcount - e == MAX_MS) begin
                    ended       = 1'b1;
                    exp_timeout = 1'b1;
                    exp_time    = MAX_MS;
                end
            end
        end
        if (!ended) begin
            tests++;
            fails++;
            $display("FAIL %s budget: trial did not end within %0d cycles", name, limit);
        end

        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (bus.done !== !exp_early || bus.early !== exp_early || bus.timeout !== exp_timeout ||
                bus.reaction_time !== CNT_W'(exp_time) || bus.led !== 1'b0) begin
                fails++;
                $display("FAIL %s result[%0d]: done=%b early=%b timeout=%b time=%0d led=%b, expected done=%b early=%b timeout=%b time=%0d led=0",
                         name, k, bus.done, bus.early, bus.timeout, bus.reaction_time, bus.led,
                         !exp_early, exp_early, exp_timeout, exp_time);
            end
            bus.start = 1'b0;
            bus.stop  = $urandom_range(1);
            bus.tick  = 1'b1;
        end
        drive_idle();
    endtask

    task automatic test_reset();
        drive_idle();
        bus.delay = 12'd0;
        #23;
        tests++;
        if (bus.delay_req !== 1'b0 || bus.led !== 1'b0 || bus.done !== 1'b0 || bus.early !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.reaction_time !== '0) begin
            fails++;
            $display("FAIL reset: req=%b led=%b done=%b early=%b timeout=%b time=%0d, expected all 0",
                     bus.delay_req, bus.led, bus.done, bus.early, bus.timeout, bus.reaction_time);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.stop = 1'b1;
            bus.tick = 1'b1;
            @(negedge clk);
            tests++;
            if (bus.delay_req !== 1'b0 || bus.led !== 1'b0 || bus.done !== 1'b0 || bus.early !== 1'b0) begin
                fails++;
                $display("FAIL idle_ignore[%0d]: req=%b led=%b done=%b early=%b, expected all 0",
                         k, bus.delay_req, bus.led, bus.done, bus.early);
            end
        end
        drive_idle();
    endtask

    task automatic test_nominal();
        run_trial(12'hA50, 2640 + 237, 100, 1'b0, 1'b0, 1'b0, "nominal");
    endtask

    task automatic test_early();
        run_trial(12'h100, 100, 100, 1'b0, 1'b0, 1'b0, "early");
    endtask

    task automatic test_timeout();
        run_trial(12'd5, 5 + MAX_MS + 100, 100, 1'b0, 1'b0, 1'b0, "timeout");
    endtask

    task automatic test_zero_delay();
        run_trial(12'd0, MIN_DELAY + 3, 100, 1'b0, 1'b0, 1'b0, "zero_delay");
    endtask

    task automatic test_collisions();
        run_trial(12'd10, 10 + 41, 60, 1'b1, 1'b0, 1'b1, "collide");
        run_trial(12'd20, 7, 60, 1'b1, 1'b0, 1'b1, "collide_wait");
    endtask

    task automatic test_back_to_back();
        run_trial(12'd3, 3 + 12, 100, 1'b0, 1'b1, 1'b0, "b2b_a");
        run_trial(12'd4, 2, 100, 1'b0, 1'b1, 1'b0, "b2b_b");
        run_trial(12'd6, 6, 100, 1'b1, 1'b0, 1'b0, "b2b_c");
    endtask

    task automatic test_reset_mid();
        drive_idle();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.delay = 12'd3;
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            bus.tick = 1'b1;
            @(negedge clk);
        end
        tests++;
        if (bus.led !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid pre: led=%b, expected 1", bus.led);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (bus.delay_req !== 1'b0 || bus.led !== 1'b0 || bus.done !== 1'b0 || bus.early !== 1'b0 ||
            bus.timeout !== 1'b0 || bus.reaction_time !== '0) begin
            fails++;
            $display("FAIL reset_mid async: req=%b led=%b done=%b early=%b timeout=%b time=%0d, expected all 0",
                     bus.delay_req, bus.led, bus.done, bus.early, bus.timeout, bus.reaction_time);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.tick = 1'b1;
            bus.stop = k[0];
            @(negedge clk);
            tests++;
            if (bus.led !== 1'b0 || bus.done !== 1'b0 || bus.early !== 1'b0 || bus.delay_req !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid idle[%0d]: led=%b done=%b early=%b req=%b, expected all 0",
                         k, bus.led, bus.done, bus.early, bus.delay_req);
            end
        end
        drive_idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic [11:0] d;
            int e, s;
            d = ($urandom_range(9) == 0) ? 12'd0 : 12'($urandom_range(80, 1));
            e = (d == 12'd0) ? MIN_DELAY : int'(d);
            s = $urandom_range(e + 100, 0);
            run_trial(d, s, $urandom_range(100, 25), 1'($urandom_range(1)),
                      1'($urandom_range(1)), 1'($urandom_range(1)), "random");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nominal();
        test_early();
        test_timeout();
        test_zero_delay();
        test_collisions();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
